// File: rtl/ctrl_pipe_pkg.sv
// Control-bundle layout shared by the EX/MEM/WB control pipeline.
// Bit positions fix how each stage register packs its fields.
package ctrl_pipe_pkg;

    // EX bundle without regdst; valid rides on top as one extra bit
    localparam int CTRL_E_W = 15;
    localparam int E_W      = CTRL_E_W + 1;
    localparam int M_W      = 9;
    localparam int W_W      = 8;

    localparam int E_VALID     = 15;
    localparam int E_REGWRITE  = 14;
    localparam int E_ALUSRC    = 13;
    localparam int E_BRANCH    = 12;
    localparam int E_MEMWRITE  = 11;
    localparam int E_MEMTOREG  = 10;
    localparam int E_JUMP      = 9;
    localparam int E_ALUOP_LSB = 5;

    localparam int M_VALID    = 8;
    localparam int M_REGWRITE = 7;
    localparam int M_MEMWRITE = 6;
    localparam int M_MEMTOREG = 5;

    localparam int W_VALID    = 7;
    localparam int W_REGWRITE = 6;
    localparam int W_MEMTOREG = 5;

    localparam int WREG_LSB = 0;

    localparam logic [3:0]     ALUOP_ORI = 4'b0011;
    localparam logic [M_W-1:0] M_BUBBLE  = '0;
    localparam logic [W_W-1:0] W_BUBBLE  = '0;

    function automatic logic [4:0] dest_reg(input logic regdst,
                                            input logic [4:0] rt,
                                            input logic [4:0] rd);
        return regdst ? rd : rt;
    endfunction

    function automatic logic [E_W-1:0] e_bubble(input logic [3:0] aluop);
        return {7'b0, aluop, 5'b0};
    endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage register: clr loads the bubble pattern, en=0 holds.
// Latency 1 cycle; clr has priority over en, rst over both.
module ctrl_stage_reg #(
    parameter int             W      = 8,
    parameter logic [W-1:0]   BUBBLE = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = BUBBLE;
        end else if (en) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= BUBBLE;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/ctrl_pipe.sv
// Carries decoded controls and destination register from ID through EX/MEM/WB.
// D->E->M->W one cycle per stage; stall_e holds EX and bubbles MEM, flush_e bubbles EX.
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter logic [3:0] BUBBLE_ALUOP = 4'b0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_d,
    input  logic        regwrite_d,
    input  logic        regdst_d,
    input  logic        alusrc_d,
    input  logic        branch_d,
    input  logic        memwrite_d,
    input  logic        memtoreg_d,
    input  logic        jump_d,
    input  logic [3:0]  aluop_d,
    input  logic [4:0]  rt_d,
    input  logic [4:0]  rd_d,
    input  logic        stall_e,
    input  logic        flush_e,
    output logic        valid_e,
    output logic        regwrite_e,
    output logic        alusrc_e,
    output logic        branch_e,
    output logic        memwrite_e,
    output logic        memtoreg_e,
    output logic        jump_e,
    output logic [3:0]  aluop_e,
    output logic [4:0]  writereg_e,
    output logic        valid_m,
    output logic        regwrite_m,
    output logic        memwrite_m,
    output logic        memtoreg_m,
    output logic [4:0]  writereg_m,
    output logic        valid_w,
    output logic        regwrite_w,
    output logic        memtoreg_w,
    output logic [4:0]  writereg_w,
    output logic [31:0] instret
);

    localparam logic [E_W-1:0] E_BUBBLE = e_bubble(BUBBLE_ALUOP);

    logic [E_W-1:0] e_in, e_q;
    logic [M_W-1:0] m_in, m_q;
    logic [W_W-1:0] w_in, w_q;
    logic [31:0]    instret_q, instret_d;

    // regdst is resolved here and never travels past D->E
    always_comb begin
        e_in = E_BUBBLE;
        if (valid_d) begin
            e_in = {1'b1, regwrite_d, alusrc_d, branch_d, memwrite_d, memtoreg_d,
                    jump_d, aluop_d, dest_reg(regdst_d, rt_d, rd_d)};
        end
        m_in = {e_q[E_VALID], e_q[E_REGWRITE], e_q[E_MEMWRITE], e_q[E_MEMTOREG],
                e_q[WREG_LSB +: 5]};
        w_in = {m_q[M_VALID], m_q[M_REGWRITE], m_q[M_MEMTOREG], m_q[WREG_LSB +: 5]};
        instret_d = instret_q + {31'b0, w_q[W_VALID]};
    end

    // Flush beats stall: EX bubbles and MEM still receives the old EX bundle
    ctrl_stage_reg #(.W(E_W), .BUBBLE(E_BUBBLE)) u_stage_e (
        .clk(clk), .rst(rst), .en(~stall_e), .clr(flush_e), .d(e_in), .q(e_q)
    );

    ctrl_stage_reg #(.W(M_W), .BUBBLE(M_BUBBLE)) u_stage_m (
        .clk(clk), .rst(rst), .en(1'b1), .clr(stall_e & ~flush_e), .d(m_in), .q(m_q)
    );

    ctrl_stage_reg #(.W(W_W), .BUBBLE(W_BUBBLE)) u_stage_w (
        .clk(clk), .rst(rst), .en(1'b1), .clr(1'b0), .d(w_in), .q(w_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign valid_e    = e_q[E_VALID];
    assign regwrite_e = e_q[E_REGWRITE];
    assign alusrc_e   = e_q[E_ALUSRC];
    assign branch_e   = e_q[E_BRANCH];
    assign memwrite_e = e_q[E_MEMWRITE];
    assign memtoreg_e = e_q[E_MEMTOREG];
    assign jump_e     = e_q[E_JUMP];
    assign aluop_e    = e_q[E_ALUOP_LSB +: 4];
    assign writereg_e = e_q[WREG_LSB +: 5];

    assign valid_m    = m_q[M_VALID];
    assign regwrite_m = m_q[M_REGWRITE];
    assign memwrite_m = m_q[M_MEMWRITE];
    assign memtoreg_m = m_q[M_MEMTOREG];
    assign writereg_m = m_q[WREG_LSB +: 5];

    assign valid_w    = w_q[W_VALID];
    assign regwrite_w = w_q[W_REGWRITE];
    assign memtoreg_w = w_q[W_MEMTOREG];
    assign writereg_w = w_q[WREG_LSB +: 5];

    assign instret    = instret_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: stage-level model checked every cycle plus literal checks.
module tb_ctrl_pipe;

    localparam logic [3:0] TB_BUB = 4'b1010;
    localparam logic [3:0] ORI    = 4'b0011;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_d, regwrite_d, regdst_d, alusrc_d, branch_d, memwrite_d, memtoreg_d, jump_d;
    logic [3:0]  aluop_d;
    logic [4:0]  rt_d, rd_d;
    logic        stall_e, flush_e;
    logic        valid_e, regwrite_e, alusrc_e, branch_e, memwrite_e, memtoreg_e, jump_e;
    logic [3:0]  aluop_e;
    logic [4:0]  writereg_e;
    logic        valid_m, regwrite_m, memwrite_m, memtoreg_m;
    logic [4:0]  writereg_m;
    logic        valid_w, regwrite_w, memtoreg_w;
    logic [4:0]  writereg_w;
    logic [31:0] instret;

    ctrl_pipe #(.BUBBLE_ALUOP(TB_BUB)) dut (
        .clk(clk), .rst(rst), .valid_d(valid_d), .regwrite_d(regwrite_d),
        .regdst_d(regdst_d), .alusrc_d(alusrc_d), .branch_d(branch_d),
        .memwrite_d(memwrite_d), .memtoreg_d(memtoreg_d), .jump_d(jump_d),
        .aluop_d(aluop_d), .rt_d(rt_d), .rd_d(rd_d), .stall_e(stall_e), .flush_e(flush_e),
        .valid_e(valid_e), .regwrite_e(regwrite_e), .alusrc_e(alusrc_e), .branch_e(branch_e),
        .memwrite_e(memwrite_e), .memtoreg_e(memtoreg_e), .jump_e(jump_e),
        .aluop_e(aluop_e), .writereg_e(writereg_e), .valid_m(valid_m),
        .regwrite_m(regwrite_m), .memwrite_m(memwrite_m), .memtoreg_m(memtoreg_m),
        .writereg_m(writereg_m), .valid_w(valid_w), .regwrite_w(regwrite_w),
        .memtoreg_w(memtoreg_w), .writereg_w(writereg_w), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       valid, regwrite, alusrc, branch, memwrite, memtoreg, jump;
        logic [3:0] aluop;
        logic [4:0] wreg;
    } instr_t;

    instr_t      m_e, m_m, m_w;
    logic [31:0] m_instret;
    int          load_req = 0;
    int          load_seen = 0;
    bit          chk_en = 1'b0;
    int          n_cyc = 0, e_cyc = 0, n_lit = 0, e_lit = 0;

    function automatic instr_t bubble();
        instr_t b;
        b = '0;
        b.aluop = TB_BUB;
        return b;
    endfunction

    // Model: what each stage must hold, straight from the stage-update rules
    always @(posedge clk) begin
        instr_t cap;
        logic [31:0] base;
        cap = bubble();
        if (valid_d) begin
            cap = '{1'b1, regwrite_d, alusrc_d, branch_d, memwrite_d, memtoreg_d, jump_d,
                    aluop_d, (regdst_d ? rd_d : rt_d)};
        end
        if (rst) begin
            m_e = bubble(); m_m = bubble(); m_w = bubble(); m_instret = 0;
            load_seen = load_req;
        end else begin
            base = (load_req != load_seen) ? 32'hFFFF_FFFF : m_instret;
            load_seen = load_req;
            m_instret = base + (m_w.valid ? 32'd1 : 32'd0);
            m_w = m_m;
            if (flush_e) begin
                m_m = m_e; m_e = bubble();
            end else if (stall_e) begin
                m_m = bubble();
            end else begin
                m_m = m_e; m_e = cap;
            end
        end
    end

    always @(negedge clk) begin
        logic [64:0] act, exp;
        if (chk_en) begin
            act = {valid_e, regwrite_e, alusrc_e, branch_e, memwrite_e, memtoreg_e, jump_e,
                   aluop_e, writereg_e, valid_m, regwrite_m, memwrite_m, memtoreg_m,
                   writereg_m, valid_w, regwrite_w, memtoreg_w, writereg_w, instret};
            exp = {m_e, m_m.valid, m_m.regwrite, m_m.memwrite, m_m.memtoreg, m_m.wreg,
                   m_w.valid, m_w.regwrite, m_w.memtoreg, m_w.wreg, m_instret};
            n_cyc++;
            if (act !== exp) begin
                e_cyc++;
                $display("FAIL model_cmp t=%0t got %h expected %h", $time, act, exp);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_lit++;
        if (act !== exp) begin
            e_lit++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic rdst, input logic asrc,
                         input logic br, input logic mw, input logic m2r, input logic j,
                         input logic [3:0] op, input logic [4:0] rt, input logic [4:0] rd);
        valid_d = v; regwrite_d = rw; regdst_d = rdst; alusrc_d = asrc; branch_d = br;
        memwrite_d = mw; memtoreg_d = m2r; jump_d = j; aluop_d = op; rt_d = rt; rd_d = rd;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 5'd0, 5'd0);
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; stall_e = 1'b0; flush_e = 1'b0;
        idle();
        tick(2);
        chk("reset_aluop_e", {28'b0, aluop_e}, {28'b0, TB_BUB});
        chk("reset_instret", instret, 32'd0);
        chk("reset_valid_w", {31'b0, valid_w}, 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // ORI: regwrite, alusrc, rt=5, rd=9, regdst=0
        drive(1, 1, 0, 1, 0, 0, 0, 0, ORI, 5'd5, 5'd9);
        tick(1); idle();
        chk("ori_writereg_e", {27'b0, writereg_e}, 32'd5);
        chk("ori_aluop_e", {28'b0, aluop_e}, {28'b0, ORI});
        tick(1);
        chk("ori_regwrite_m", {31'b0, regwrite_m}, 32'd1);
        tick(1);
        chk("ori_regwrite_w", {31'b0, regwrite_w}, 32'd1);
        chk("ori_writereg_w", {27'b0, writereg_w}, 32'd5);
        tick(1);
        chk("ori_instret", instret, 32'd1);

        // R-type destination
        drive(1, 1, 1, 0, 0, 0, 0, 0, 4'd2, 5'd3, 5'd17);
        tick(1); idle();
        chk("rtype_writereg_e", {27'b0, writereg_e}, 32'd17);
        tick(2);
        chk("rtype_writereg_w", {27'b0, writereg_w}, 32'd17);
        tick(1);

        // Two-cycle stall on instruction A (rt=7)
        drive(1, 1, 0, 0, 0, 0, 0, 0, 4'd1, 5'd7, 5'd0);
        tick(1);
        chk("stall_e0_wreg", {27'b0, writereg_e}, 32'd7);
        stall_e = 1'b1;
        drive(1, 1, 0, 0, 0, 0, 0, 0, 4'd1, 5'd8, 5'd0);
        tick(1);
        chk("stall_e1_wreg", {27'b0, writereg_e}, 32'd7);
        chk("stall_m1_valid", {31'b0, valid_m}, 32'd0);
        tick(1);
        chk("stall_e2_wreg", {27'b0, writereg_e}, 32'd7);
        chk("stall_m2_valid", {31'b0, valid_m}, 32'd0);
        stall_e = 1'b0;
        tick(1); idle();
        chk("stall_resume_m", {26'b0, valid_m, writereg_m}, {26'b0, 1'b1, 5'd7});
        chk("stall_resume_e", {27'b0, writereg_e}, 32'd8);
        tick(1);
        chk("stall_late_retire", {26'b0, valid_w, writereg_w}, {26'b0, 1'b1, 5'd7});
        tick(3);

        // Flush together with stall: C (rt=11, memwrite) moves on, EX bubbles
        drive(1, 0, 0, 0, 0, 1, 0, 0, 4'd0, 5'd11, 5'd0);
        tick(1);
        chk("flush_pre_e", {27'b0, writereg_e}, 32'd11);
        flush_e = 1'b1; stall_e = 1'b1;
        drive(1, 1, 0, 0, 0, 0, 0, 0, 4'd4, 5'd12, 5'd0);
        tick(1);
        flush_e = 1'b0; stall_e = 1'b0; idle();
        chk("flush_valid_e", {31'b0, valid_e}, 32'd0);
        chk("flush_aluop_e", {28'b0, aluop_e}, {28'b0, TB_BUB});
        chk("flush_m", {25'b0, valid_m, memwrite_m, writereg_m}, {25'b0, 2'b11, 5'd11});
        tick(1);
        chk("flush_w", {26'b0, valid_w, writereg_w}, {26'b0, 1'b1, 5'd11});
        tick(4);

        // Counter wrap
        #1;
        force dut.instret_q = 32'hFFFF_FFFF;
        load_req++;
        #1;
        release dut.instret_q;
        tick(1);
        chk("wrap_loaded", instret, 32'hFFFF_FFFF);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 4'd0, 5'd1, 5'd0);
        tick(1); idle();
        tick(3);
        chk("wrap_zero", instret, 32'd0);

        // Mid-stream reset with all stages full of stores
        drive(1, 0, 0, 0, 0, 1, 0, 0, 4'd0, 5'd2, 5'd0);
        tick(3);
        chk("full_before_rst", {29'b0, valid_e, valid_m, valid_w}, 32'd7);
        rst = 1'b1; idle();
        tick(1);
        rst = 1'b0;
        chk("rst_valids", {29'b0, valid_e, valid_m, valid_w}, 32'd0);
        chk("rst_memwrite_m", {31'b0, memwrite_m}, 32'd0);
        chk("rst_instret", instret, 32'd0);

        // Mixed directed stream: stalls, flushes, bubbles and all-zero illegal bundles
        for (int i = 0; i < 40; i++) begin
            if (i % 5 == 0) begin
                drive(1, 0, 0, 0, 0, 0, 0, 0, 4'd0, 5'd0, 5'd0);
            end else begin
                drive((i % 3) != 2, i[0], i[1], i[2], i[3], i[1] ^ i[0], i[4], i[2] & i[0],
                      4'(i), 5'(i + 1), 5'(31 - i));
            end
            stall_e = (i % 7) == 3 || (i % 7) == 4;
            flush_e = (i % 9) == 5;
            tick(1);
        end
        stall_e = 1'b0; flush_e = 1'b0; idle();
        tick(5);

        $display("Simulation finished: %0d checks, %0d errors", n_cyc + n_lit, e_cyc + e_lit);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Receives the control bundle that the main decoder produces in the ID stage and carries it through EX, MEM and WB of the 5-stage MIPS pipeline, alongside the destination register number. It is the consumer end of the decoder interface. It honours hazard-unit stall and flush requests by holding or bubbling stages, and keeps a retired-instruction counter. All datapath muxes and the register-file write enable downstream are driven only from this block's stage outputs.

## Interface
- `BUBBLE_ALUOP`, default 4'b0000: aluop value carried by a bubble.
- `clk` in 1: pipeline clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `valid_d` in 1: the ID stage holds a real instruction.
- `regwrite_d, regdst_d, alusrc_d, branch_d, memwrite_d, memtoreg_d, jump_d` in 1 each: decoder controls.
- `aluop_d` in 4: decoder ALU op.
- `rt_d, rd_d` in 5 each: instruction rt and rd fields.
- `stall_e` in 1: hold the EX stage.
- `flush_e` in 1: squash the EX stage.
- `valid_e, regwrite_e, alusrc_e, branch_e, memwrite_e, memtoreg_e, jump_e` out 1 each: EX-stage controls.
- `aluop_e` out 4: EX-stage ALU op.
- `writereg_e` out 5: EX-stage destination register.
- `valid_m, regwrite_m, memwrite_m, memtoreg_m` out 1 each: MEM-stage controls.
- `writereg_m` out 5: MEM-stage destination register.
- `valid_w, regwrite_w, memtoreg_w` out 1 each: WB-stage controls.
- `writereg_w` out 5: WB-stage destination register.
- `instret` out 32: count of instructions retired from WB.

## Operation
- Bubble: every control bit is 0, `aluop` is `BUBBLE_ALUOP`, `writereg` is 0 and `valid` is 0. A bubble never writes the register file or memory.
- D→E capture: `writereg` = `regdst_d ? rd_d : rt_d`, computed before the register.
  - If `valid_d`=0, the stage captures a bubble.
  - `regdst` is consumed at D→E and is not carried further.
- EX update, in priority order:
  - `flush_e`=1: EX loads a bubble. MEM loads the old EX contents.
  - Otherwise `stall_e`=1: EX holds its contents. MEM loads a bubble.
  - Otherwise: EX loads the D capture and MEM loads the old EX contents.
- MEM and WB never stall. WB loads the old MEM contents every cycle.
- `instret` increments by 1 in every cycle in which `valid_w`=1. It wraps from 0xFFFFFFFF to 0.
- Reset: every output is 0, `aluop_e`=`BUBBLE_ALUOP`, and `instret`=0. Reset overrides `stall_e` and `flush_e`.
- A reset asserted mid-stream drops all in-flight instructions. There is no partial retirement.
- The block does no decoding of its own. Illegal opcodes arrive as an all-zero bundle and travel as harmless no-ops, with `valid`=1.

## Timing
- All state is registered on the `clk` rising edge. No output depends combinationally on any input.
- A bundle presented at D in cycle n appears at E in n+1, at M in n+2 and at W in n+3, if there is no stall.
- A stall held for k cycles delays the instruction in EX by k cycles and inserts k bubbles into M.
- If `flush_e` and `stall_e` are asserted in the same cycle, flush wins.
  - The ID stage must itself hold during `stall_e`. That is the hazard unit's job.
  - The instruction at D in that cycle is lost unless the hazard unit re-presents it.
- `instret` updates one cycle after the WB-valid cycle, so it is readable in cycle n+4 for an instruction issued in cycle n.

## Structure
- `defines.h` gets:
  - `CTRL_E_W` (=15, the EX-stage bundle width without regdst).
  - Bubble constants.
  - Bit-position macros for packing the bundle.
- One sub-module, `ctrl_stage_reg`: a parameterised-width register with synchronous `rst`, `en` (hold when 0) and `clr` (load bubble). `ctrl_pipe` instantiates it three times, once each for E, M and W.

## Test plan
- Reset then free-run:
  - Pulse `rst`, then drive ORI controls (regwrite=1, alusrc=1, aluop=ORI_OP, rt_d=5, rd_d=9, regdst=0) for 1 cycle with `valid_d`=1.
  - Required: `writereg_e`=5 in cycle 1, `regwrite_m`=1 in cycle 2, `regwrite_w`=1 with `writereg_w`=5 in cycle 3, `instret`=1 in cycle 4.
- R-type destination:
  - Drive regdst=1, rd_d=17, rt_d=3.
  - Required: `writereg_e`=17, then `writereg_w`=17 three cycles after issue.
- Stall for 2 cycles:
  - Required: EX holds the same bundle for 3 cycles, `valid_m`=0 for exactly 2 cycles, and the instruction retires 2 cycles late.
- Flush plus stall in the same cycle:
  - Required: `valid_e`=0 in the next cycle, and the old EX instruction still reaches M.
- Counter wrap:
  - Force `instret`=0xFFFFFFFF, then retire one instruction.
  - Required: `instret`=0.
- Mid-stream reset:
  - Fill all stages with `valid`=1 and memwrite=1, then assert `rst`.
  - Required: `valid_e`, `valid_m` and `valid_w`, `memwrite_m` and `instret` are all 0 on the next edge.
